// File: rtl/revela_papeis_if.sv
// Handshake/status bundle between the role-reveal controller and its user.
// The master drives the round controls and the game word; the slave reports progress.
interface revela_papeis_if #(
  parameter int N_JOG = 10
);
  logic             iniciar;
  logic             avancar;
  logic [N_JOG-1:0] jogo;
  logic [3:0]       jogador;
  logic             papel;
  logic             mostra;
  logic             pronto;
  logic [3:0]       num_lobos;
  logic [1:0]       estado;

  modport master (
    output iniciar, avancar, jogo,
    input  jogador, papel, mostra, pronto, num_lobos, estado
  );

  modport slave (
    input  iniciar, avancar, jogo,
    output jogador, papel, mostra, pronto, num_lobos, estado
  );
endinterface

// File: rtl/revela_papeis.sv
// Role-reveal controller: walks every player through a hidden/revealed cycle,
// showing each one's role from a game word captured at the start of the round.
module revela_papeis #(
  parameter int N_JOG    = 10,
  parameter int T_MOSTRA = 50_000_000
) (
  input  logic           clock,
  input  logic           reset,
  revela_papeis_if.slave bus
);
  localparam int TW = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(T_MOSTRA - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(N_JOG - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    MOSTRA = 2'd2,
    FIM    = 2'd3
  } estado_t;

  estado_t          state_r;
  logic [N_JOG-1:0] snap_r;
  logic [3:0]       idx_r;
  logic [TW-1:0]    timer_r;
  logic [3:0]       num_lobos_r;
  logic             papel_r;

  logic [N_JOG-1:0] snap_sh_s;
  logic             papel_bit_s;
  logic             fim_mostra_s;

  function automatic logic [3:0] popcount(input logic [N_JOG-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < N_JOG; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  assign snap_sh_s    = snap_r >> idx_r;
  assign papel_bit_s  = snap_sh_s[0];
  // A press on the timeout cycle merges with the timeout into one end event.
  assign fim_mostra_s = bus.avancar || (timer_r == TIMER_LAST);

  // Round FSM: snapshot capture, per-player reveal timing and index walk.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= OCIOSO;
      snap_r      <= '0;
      idx_r       <= 4'd0;
      timer_r     <= '0;
      num_lobos_r <= 4'd0;
      papel_r     <= 1'b0;
    end else begin
      case (state_r)
        OCIOSO, FIM: begin
          if (bus.iniciar) begin
            snap_r      <= bus.jogo;
            idx_r       <= 4'd0;
            timer_r     <= '0;
            num_lobos_r <= popcount(bus.jogo);
            papel_r     <= 1'b0;
            state_r     <= ESPERA;
          end
        end
        ESPERA: begin
          if (bus.avancar) begin
            timer_r <= '0;
            papel_r <= papel_bit_s;
            state_r <= MOSTRA;
          end
        end
        MOSTRA: begin
          if (fim_mostra_s) begin
            papel_r <= 1'b0;
            if (idx_r == IDX_LAST) begin
              state_r <= FIM;
            end else begin
              idx_r   <= idx_r + 4'd1;
              state_r <= ESPERA;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r <= OCIOSO;
          papel_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.jogador   = idx_r;
  assign bus.papel     = papel_r;
  assign bus.mostra    = (state_r == MOSTRA);
  assign bus.pronto    = (state_r == FIM);
  assign bus.num_lobos = num_lobos_r;
  assign bus.estado    = state_r;
endmodule

// File: tb/tb_revela_papeis.sv
// Directed bench for revela_papeis with a short reveal timeout (T_MOSTRA=8).
module tb_revela_papeis;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  revela_papeis_if #(.N_JOG(10)) bus ();

  revela_papeis #(.N_JOG(10), .T_MOSTRA(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_av();
    bus.avancar = 1'b1;
    tick();
    bus.avancar = 1'b0;
  endtask

  task automatic pulse_ini();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
  endtask

  initial begin
    logic [9:0] papeis_exp;
    int         cnt;
    n_cmp = 0;
    n_err = 0;
    papeis_exp = 10'b0000100101;
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.avancar = 1'b0;
    bus.jogo    = 10'd0;
    tick();
    tick();
    chk("rst_estado", bus.estado, 0);
    chk("rst_jogador", bus.jogador, 0);
    chk("rst_papel", bus.papel, 0);
    chk("rst_mostra", bus.mostra, 0);
    chk("rst_pronto", bus.pronto, 0);
    chk("rst_num_lobos", bus.num_lobos, 0);
    reset = 1'b0;

    // avancar in OCIOSO alone is ignored
    pulse_av();
    chk("ocioso_av_estado", bus.estado, 0);

    // iniciar together with avancar in OCIOSO
    bus.jogo = 10'b0000100101;
    bus.avancar = 1'b1;
    pulse_ini();
    bus.avancar = 1'b0;
    chk("ini_estado", bus.estado, 1);
    chk("ini_num_lobos", bus.num_lobos, 3);
    chk("ini_jogador", bus.jogador, 0);
    chk("ini_mostra", bus.mostra, 0);

    // full walk, changing jogo mid-round
    for (int p = 0; p < 10; p++) begin
      if (p == 5) bus.jogo = 10'b1111111111;
      pulse_av();
      chk("walk_mostra", bus.mostra, 1);
      chk("walk_papel", bus.papel, papeis_exp[p]);
      chk("walk_jogador", bus.jogador, p);
      tick();
      pulse_av();
      chk("walk_hide_papel", bus.papel, 0);
      if (p < 9) begin
        chk("walk_next_estado", bus.estado, 1);
        chk("walk_next_jogador", bus.jogador, p + 1);
      end else begin
        chk("walk_pronto", bus.pronto, 1);
        chk("walk_fim_jogador", bus.jogador, 9);
        chk("walk_fim_estado", bus.estado, 3);
      end
    end
    chk("snap_num_lobos", bus.num_lobos, 3);
    pulse_av();
    chk("fim_av_estado", bus.estado, 3);
    chk("fim_av_jogador", bus.jogador, 9);

    // restart from FIM with the new word
    pulse_ini();
    chk("restart_estado", bus.estado, 1);
    chk("restart_num_lobos", bus.num_lobos, 10);
    chk("restart_jogador", bus.jogador, 0);

    // timeout: no further presses
    pulse_av();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mostra !== 1'b1) break;
      cnt++;
      tick();
    end
    chk("timeout_cycles", cnt, 8);
    chk("timeout_estado", bus.estado, 1);
    chk("timeout_jogador", bus.jogador, 1);

    // iniciar ignored in ESPERA
    bus.jogo = 10'd0;
    pulse_ini();
    chk("espera_ini_estado", bus.estado, 1);
    chk("espera_ini_jogador", bus.jogador, 1);
    chk("espera_ini_num_lobos", bus.num_lobos, 10);

    // avancar on the timeout cycle -> single advance
    pulse_av();
    chk("coinc_enter_papel", bus.papel, 1);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    chk("mostra_ini_estado", bus.estado, 2);
    repeat (6) tick();
    chk("coinc_pre_mostra", bus.mostra, 1);
    pulse_av();
    chk("coinc_estado", bus.estado, 1);
    chk("coinc_jogador", bus.jogador, 2);
    tick();
    chk("coinc_hold_jogador", bus.jogador, 2);

    // reach MOSTRA with jogador=4, then reset together with avancar
    repeat (5) pulse_av();
    chk("pre_rst_jogador", bus.jogador, 4);
    chk("pre_rst_papel", bus.papel, 1);
    reset = 1'b1;
    bus.avancar = 1'b1;
    tick();
    reset = 1'b0;
    bus.avancar = 1'b0;
    chk("midrst_estado", bus.estado, 0);
    chk("midrst_jogador", bus.jogador, 0);
    chk("midrst_papel", bus.papel, 0);
    chk("midrst_mostra", bus.mostra, 0);
    chk("midrst_pronto", bus.pronto, 0);
    chk("midrst_num_lobos", bus.num_lobos, 0);
    pulse_av();
    tick();
    pulse_av();
    chk("postrst_estado", bus.estado, 0);
    chk("postrst_jogador", bus.jogador, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
